// File: rtl/m_req_tracker.sv
// m_req_tracker: per-master outstanding request tracker.
// Holds up to DEPTH {slave, cmd} entries in issue order and steps the head
// entry through WAIT -> W_ACK -> (W_DATA) -> retire. Only the head is ever
// active, so issue is single-outstanding and in order.
// Optional feature: define TRK_TIMEOUT_EN to build a response watchdog that
// retires a stuck head after TIMEOUT_CYC cycles with done_err set.
module m_req_tracker #(
    parameter int ADDR_W      = 32,
    parameter int SLAVE_W     = 1,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic                       req_cmd,
    output logic                       req_ready,
    input  logic                       grant,
    input  logic                       ack_in,
    input  logic                       rdata_valid,
    output logic                       head_valid,
    output logic [SLAVE_W-1:0]         head_slave,
    output logic                       head_cmd,
    output logic [1:0]                 head_stat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       done,
    output logic                       done_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        NO_REQ = 2'd0,
        WAIT   = 2'd1,
        W_ACK  = 2'd2,
        W_DATA = 2'd3
    } stat_e;

    typedef struct packed {
        logic [SLAVE_W-1:0] slave;
        logic               cmd;
    } ent_t;

    // Misconfiguration marker: DEPTH must be a power of two >= 2 and the
    // watchdog limit must be at least one cycle.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        logic unused_bad_cfg;
        assign unused_bad_cfg = 1'b0;
    end

    // Only the slave-select MSBs of the address are stored.
    if (ADDR_W > SLAVE_W) begin : g_addr_sink
        logic unused_addr;
        assign unused_addr = ^req_addr[ADDR_W-SLAVE_W-1:0];
    end

    ent_t [DEPTH-1:0]  mem;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    stat_e             state;
    stat_e             state_nx;
    ent_t              head_ent;

    logic push;
    logic hit_ack;
    logic hit_data;
    logic retire_ok;
    logic tmo_hit;
    logic tmo_err;
    logic retire;

    assign head_ent   = mem[rd_ptr];
    assign req_ready  = (cnt != CNT_W'(DEPTH));
    assign head_valid = (cnt != '0);
    assign head_slave = head_valid ? head_ent.slave : '0;
    assign head_cmd   = head_valid ? head_ent.cmd   : 1'b0;
    assign head_stat  = state;
    assign count      = cnt;

    // A push is refused whenever the queue is full at the edge, regardless
    // of a retirement in the same cycle.
    assign push      = req_valid && req_ready;
    assign hit_ack   = (state == W_ACK)  && ack_in;
    assign hit_data  = (state == W_DATA) && rdata_valid;
    assign retire_ok = (hit_ack && head_ent.cmd) || hit_data;
    // The expected event wins over a coincident watchdog expiry.
    assign tmo_err   = tmo_hit && !hit_ack && !hit_data;
    assign retire    = retire_ok || tmo_err;

`ifdef TRK_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_resp;

    assign in_resp = (state == W_ACK) || (state == W_DATA);
    // Compare against LIMIT-1 so the retirement edge is the one on which the
    // counter would reach TIMEOUT_CYC.
    assign tmo_hit = in_resp && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Watchdog: restart on entry to a response-wait state, count while in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state_nx != state) && ((state_nx == W_ACK) || (state_nx == W_DATA))) begin
            tmo_cnt <= '0;
        end else if (in_resp) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Occupancy after this edge; push and retire together leave it unchanged.
    always_comb begin
        cnt_nx = cnt + CNT_W'(push) - CNT_W'(retire);
    end

    // Head FSM next state; a retirement promotes the next entry straight to WAIT.
    always_comb begin
        state_nx = state;
        case (state)
            NO_REQ: if (push)     state_nx = WAIT;
            WAIT:   if (grant)    state_nx = W_ACK;
            W_ACK:  if (hit_ack && !head_ent.cmd) state_nx = W_DATA;
            W_DATA: state_nx = W_DATA;
            default: state_nx = NO_REQ;
        endcase
        if (retire) begin
            state_nx = (cnt_nx != '0) ? WAIT : NO_REQ;
        end
    end

    // Queue storage, pointers, head state and the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            state    <= NO_REQ;
            done     <= 1'b0;
            done_err <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{slave: req_addr[ADDR_W-1 -: SLAVE_W], cmd: req_cmd};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt      <= cnt_nx;
            state    <= state_nx;
            done     <= retire;
            done_err <= tmo_err;
        end
    end

endmodule

// File: doc/m_req_tracker.md
Name: m_req_tracker

Overview:
- Clocked, parametrised per-master request tracker for the master/slave interconnect.
- Queues up to DEPTH outstanding master requests (slave index + cmd) in issue order.
- Steps the head request through WAIT -> W_ACK -> W_DATA -> NO_REQ from grant, ack and read-data events.
- Exposes head state to the arbiter/router and pulses completion back to the master side.

Parameters:
- ADDR_W, 32, master address width.
- SLAVE_W, 1, slave index width; index = req_addr[ADDR_W-1 -: SLAVE_W].
- DEPTH, 4, max outstanding requests; power of two, >= 2.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with TRK_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  new master request.
- req_addr  in  ADDR_W  request address; MSBs select the slave.
- req_cmd  in  1  1 = write, 0 = read.
- req_ready  out  1  queue not full.
- grant  in  1  head request sent to slave.
- ack_in  in  1  slave ack for the head request.
- rdata_valid  in  1  read data delivered for the head request.
- head_valid  out  1  queue non-empty.
- head_slave  out  SLAVE_W  slave index of the head entry.
- head_cmd  out  1  cmd of the head entry.
- head_stat  out  2  0 NO_REQ, 1 WAIT, 2 W_ACK, 3 W_DATA.
- count  out  $clog2(DEPTH)+1  entries held.
- done  out  1  one-cycle pulse when the head retires.
- done_err  out  1  set with done when retirement is due to timeout (0 without TRK_TIMEOUT_EN).

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low clears all state immediately. Name the ports clk and rst_n.
- Reset values:
  - req_ready = 1.
  - head_valid = 0, head_slave = 0, head_cmd = 0.
  - head_stat = NO_REQ, count = 0.
  - done = 0, done_err = 0.
- Queue:
  - Circular FIFO of {slave, cmd}; rd/wr pointers wrap modulo DEPTH.
  - Push when req_valid && req_ready.
  - req_ready = (count != DEPTH), combinational from count.
  - Push while full is dropped, even if the head retires in the same cycle.
  - A request pushed at edge k is visible at the head after edge k if the queue was empty.
  - Simultaneous push and retire: count unchanged, both pointers advance.
- Head FSM (registered; events act only on head_valid):
  - NO_REQ (empty) -> WAIT when an entry becomes head.
  - WAIT + grant -> W_ACK next cycle.
  - W_ACK + ack_in:
    - cmd = 1 -> retire: done = 1 next cycle.
    - cmd = 0 -> W_DATA.
  - W_DATA + rdata_valid -> retire: done = 1 next cycle.
  - On retire the next entry, if any, enters WAIT in the same edge; otherwise NO_REQ.
- Events not matching the current state are ignored:
  - grant outside WAIT.
  - ack_in outside W_ACK.
  - rdata_valid outside W_DATA.
- Only the head is active; later entries wait in order. Issue is single-outstanding and in order.
- done is high for exactly one cycle per retirement. Back-to-back retirements give consecutive done pulses.
- head_slave and head_cmd are combinational from the head slot. Both are 0 when empty.
- Reset asserted mid-operation discards all entries. No done is produced for them.

Optional Feature:
- Macro: TRK_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (width $clog2(TIMEOUT_CYC+1)) clears on entry to W_ACK or W_DATA and increments each cycle while in either state.
  - When it reaches TIMEOUT_CYC without the expected event, the head retires with done = 1 and done_err = 1.
  - A matching event in the same cycle as the timeout wins; in that case done_err = 0.
- Undefined: no counter is built; done_err is tied to 0.

Test Plan:
- Reset, then write: req_addr = 0x8000_0000, cmd = 1 -> head_slave = 1, head_stat = 1. grant -> head_stat = 2. ack_in -> done pulse, head_stat = 0, count = 0.
- Read to slave 0: grant, ack_in -> head_stat = 3. rdata_valid 2 cycles later -> done one cycle, done_err = 0.
- Push 5 requests back-to-back with DEPTH = 4 -> req_ready drops after the 4th, 5th dropped, count = 4. Retire all -> four done pulses in order, slaves match the pushed order.
- Full queue, push + retire in the same cycle -> push dropped, count = 3. Pointers wrap correctly over 3 fill/drain rounds.
- Stray events: ack_in in WAIT and rdata_valid in W_ACK -> no state change. rst_n low in W_DATA -> all outputs return to reset values asynchronously, no done.
- With TRK_TIMEOUT_EN and TIMEOUT_CYC = 8: grant with no ack -> done = 1, done_err = 1 eight cycles after entering W_ACK. ack_in arriving on cycle 8 -> done_err = 0.
